// File: rtl/cl_cfg_arb_pkg.sv
// Shared types and constants for the cfg-bus arbiter: FSM state encoding,
// timeout read data and the requester-count ceiling.
package cl_cfg_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } cfg_arb_state_e;

   localparam logic [31:0] CFG_DEAD_DATA   = 32'hdead_beef;
   localparam int unsigned CFG_ARB_MAX_REQ = 16;

endpackage

// File: rtl/cl_rr_pick.sv
// Combinational rotate-priority picker: first set request at or above
// (ptr+1) mod NUM_REQ, wrapping, with ptr itself lowest priority.
module cl_rr_pick
   import cl_cfg_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDW     = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   output logic               any,
   output logic [IDW-1:0]     idx
);

   always_comb begin
      int unsigned j;
      any = 1'b0;
      idx = '0;
      j   = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         j = (32'(ptr) + k) % NUM_REQ;
         if (!any && req[j]) begin
            any = 1'b1;
            idx = IDW'(j);
         end
      end
   end

endmodule

// File: rtl/cl_cfg_arb.sv
// Round-robin arbiter sharing one cfg-bus target among NUM_REQ requesters,
// one transaction in flight, with a per-transaction ack timeout.
module cl_cfg_arb
   import cl_cfg_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                       clk,
   input  logic                       sync_rst_n,
   input  logic                       flr_assert,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ-1:0]         req_wr,
   input  logic [NUM_REQ*32-1:0]      req_addr,
   input  logic [NUM_REQ*32-1:0]      req_wdata,
   output logic [NUM_REQ-1:0]         rsp_valid,
   output logic [31:0]                rsp_rdata,
   output logic                       rsp_err,
   output logic [31:0]                tgt_addr,
   output logic [31:0]                tgt_wdata,
   output logic                       tgt_wr,
   output logic                       tgt_rd,
   input  logic                       tgt_ack,
   input  logic [31:0]                tgt_rdata,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id
);

   localparam int unsigned IDW = $clog2(NUM_REQ);
   localparam logic [15:0] TMO = 16'(TIMEOUT);

   cfg_arb_state_e state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] gid_q, gid_d;
   logic [31:0]    addr_q, addr_d;
   logic [31:0]    wdata_q, wdata_d;
   logic           wr_q, wr_d;
   logic [15:0]    cnt_q, cnt_d;
   logic [31:0]    rdata_q, rdata_d;
   logic           err_q, err_d;

   logic           pick_any;
   logic [IDW-1:0] pick_idx;
   logic           resp_fire;

   cl_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_pick (
      .req (req_valid),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gid_d   = gid_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               gid_d   = pick_idx;
               ptr_d   = pick_idx;
               addr_d  = req_addr[32*pick_idx +: 32];
               wdata_d = req_wdata[32*pick_idx +: 32];
               wr_d    = req_wr[pick_idx];
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d = 16'd1;
            if (tgt_ack) begin
               rdata_d = wr_q ? '0 : tgt_rdata;
               err_d   = 1'b0;
               state_d = RESP;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + 16'd1;
            // A late ack still beats the timeout when both land together.
            if (tgt_ack) begin
               rdata_d = wr_q ? '0 : tgt_rdata;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_q == TMO) begin
               rdata_d = CFG_DEAD_DATA;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flr_assert) begin
         state_d = IDLE;
         ptr_d   = '0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge sync_rst_n) begin
      if (!sync_rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gid_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // FLR suppresses both the target strobe and the completion in its own cycle.
   assign resp_fire = (state_q == RESP) && !flr_assert;

   always_comb begin
      rsp_valid = '0;
      if (resp_fire) rsp_valid[gid_q] = 1'b1;
   end

   assign rsp_rdata = resp_fire ? rdata_q : '0;
   assign rsp_err   = resp_fire ? err_q : 1'b0;
   assign tgt_wr    = (state_q == ISSUE) && wr_q && !flr_assert;
   assign tgt_rd    = (state_q == ISSUE) && !wr_q && !flr_assert;
   assign tgt_addr  = addr_q;
   assign tgt_wdata = wdata_q;
   assign busy      = (state_q != IDLE);
   assign grant_id  = gid_q;

endmodule
